// File: rtl/div_unit.sv
// Multi-cycle 32-bit radix-2 restoring divider for the DIV/DIVU path in EX.
// Produces {remainder, quotient} after 32 iterations and stalls the pipeline while busy.
module div_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        divsigned,
    input  logic        divstart,
    input  logic        annul,
    output logic [63:0] divres,
    output logic        div_ready,
    output logic        div_stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [4:0]  count;
    logic [31:0] divisor;
    logic [31:0] rem;
    logic [31:0] quo;
    logic        quo_neg;
    logic        rem_neg;

    logic        start;
    logic        last_iter;
    logic [32:0] trial;
    logic        borrow;
    logic [31:0] rem_step;
    logic [31:0] quo_step;

    function automatic logic [31:0] magnitude(input logic signed [31:0] v, input logic is_signed);
        logic [31:0] mag;
        mag = v;
        if (is_signed && v[31])
            mag = ~v + 32'd1;
        return mag;
    endfunction

    function automatic logic [31:0] negate_if(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    assign start     = (state == IDLE) && divstart && !annul;
    assign last_iter = (state == BUSY) && (count == 5'd31);

    // The dividend shifts out of the top of the quotient register, one bit per iteration.
    assign trial    = {rem, quo[31]} - {1'b0, divisor};
    assign borrow   = trial[32];
    assign rem_step = borrow ? {rem[30:0], quo[31]} : trial[31:0];
    assign quo_step = {quo[30:0], ~borrow};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (divstart) state_next = BUSY;
            BUSY:    if (count == 5'd31) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (annul)
            state_next = IDLE;
    end

    always_comb begin
        div_stall = start || (state == BUSY);
        div_ready = (state == DONE) && !annul;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count   <= 5'd0;
            divisor <= 32'd0;
            rem     <= 32'd0;
            quo     <= 32'd0;
            quo_neg <= 1'b0;
            rem_neg <= 1'b0;
        end else if (start) begin
            count   <= 5'd0;
            divisor <= magnitude(b, divsigned);
            rem     <= 32'd0;
            quo     <= magnitude(a, divsigned);
            // A zero divisor yields an all-ones quotient in both modes, so never negate it.
            quo_neg <= (a[31] ^ b[31]) & divsigned & (b != 32'd0);
            rem_neg <= a[31] & divsigned;
        end else if ((state == BUSY) && !annul) begin
            count <= count + 5'd1;
            rem   <= rem_step;
            quo   <= quo_step;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            divres <= 64'd0;
        else if (last_iter && !annul)
            divres <= {negate_if(rem_step, rem_neg), negate_if(quo_step, quo_neg)};
    end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: arithmetic reference model with per-cycle compare, plus
// directed divides with hand-computed results, annul, async reset and back-to-back cases.
module tb_div_unit;

    logic        clk;
    logic        resetn;
    logic [31:0] a;
    logic [31:0] b;
    logic        divsigned;
    logic        divstart;
    logic        annul;
    logic [63:0] divres;
    logic        div_ready;
    logic        div_stall;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          m_phase = 0;
    logic [63:0] m_res = 64'd0;
    logic [63:0] m_pend = 64'd0;
    logic [63:0] last_lit = 64'd0;

    div_unit dut (
        .clk       (clk),
        .resetn    (resetn),
        .a         (a),
        .b         (b),
        .divsigned (divsigned),
        .divstart  (divstart),
        .annul     (annul),
        .divres    (divres),
        .div_ready (div_ready),
        .div_stall (div_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        logic [31:0] qq;
        logic [31:0] rr;
        sx = x;
        sy = y;
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        if (!s) return {x % y, x / y};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        qq = sx / sy;
        rr = sx % sy;
        return {rr, qq};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference timeline: phase 0 idle, 1..32 iterating, 33 result presented.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_phase = 0;
            m_res   = 64'd0;
        end else if (annul) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (divstart) begin
                m_phase = 1;
                m_pend  = model(a, b, divsigned);
            end
        end else if (m_phase == 32) begin
            m_phase = 33;
            m_res   = m_pend;
        end else if (m_phase == 33) begin
            m_phase = 0;
        end else begin
            m_phase = m_phase + 1;
        end
    end

    always @(negedge clk) begin
        logic exp_stall;
        logic exp_ready;
        exp_stall = ((m_phase == 0) && divstart && !annul) || (m_phase >= 1 && m_phase <= 32);
        exp_ready = (m_phase == 33) && !annul;
        check("cyc_stall", div_stall, exp_stall);
        check("cyc_ready", div_ready, exp_ready);
        check("cyc_divres", divres, m_res);
    end

    task automatic do_div(input logic [31:0] ta, input logic [31:0] tbv, input logic ts,
                          input logic [63:0] lit, input string nm);
        int stalls;
        int lat;
        logic [63:0] res;
        stalls = 0;
        lat    = -1;
        res    = 64'd0;
        check({nm, "_model"}, model(ta, tbv, ts), lit);
        @(posedge clk); #1;
        a = ta; b = tbv; divsigned = ts; divstart = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_stall) stalls++;
            if (div_ready) begin
                lat = i;
                res = divres;
                break;
            end
            @(posedge clk); #1;
            if (i == 0) begin
                a = ~ta; b = ~tbv; divsigned = ~ts;
            end
        end
        @(posedge clk); #1;
        divstart = 1'b0;
        check({nm, "_res"}, res, lit);
        check({nm, "_lat"}, lat, 33);
        check({nm, "_stalls"}, stalls, 33);
        last_lit = lit;
    endtask

    task automatic wait_ready(output logic [63:0] r, output int at);
        r  = 64'd0;
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_ready) begin
                r  = divres;
                at = cyc;
                break;
            end
        end
        check("ready_seen", (at >= 0), 1'b1);
    endtask

    initial begin
        logic [63:0] r1;
        logic [63:0] r2;
        int t1;
        int t2;
        int rdy;
        resetn = 1'b1; a = 32'd0; b = 32'd0; divsigned = 1'b0; divstart = 1'b0; annul = 1'b0;
        #1 resetn = 1'b0;
        #20 resetn = 1'b1;
        @(negedge clk);
        check("reset_divres", divres, 64'd0);
        check("reset_ready", div_ready, 1'b0);
        check("reset_stall", div_stall, 1'b0);

        do_div(32'd100,        32'd7,          1'b0, {32'd2, 32'd14},               "u_100_7");
        do_div(32'hFFFFFFF9,   32'd2,          1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD},  "s_m7_2");
        do_div(32'd7,          32'hFFFFFFFE,   1'b1, {32'h00000001, 32'hFFFFFFFD},  "s_7_m2");
        do_div(32'hFFFFFF9C,   32'd7,          1'b1, {32'hFFFFFFFE, 32'hFFFFFFF2},  "s_m100_7");
        do_div(32'h80000000,   32'd3,          1'b0, {32'd2, 32'h2AAAAAAA},         "u_big_3");
        do_div(32'h80000000,   32'hFFFFFFFF,   1'b1, {32'h0, 32'h80000000},         "s_ovf");
        do_div(32'h12345678,   32'd0,          1'b0, {32'h12345678, 32'hFFFFFFFF},  "u_div0");
        do_div(32'h12345678,   32'd0,          1'b1, {32'h12345678, 32'hFFFFFFFF},  "s_div0");
        do_div(32'hFFFFFFF9,   32'd0,          1'b1, {32'hFFFFFFF9, 32'hFFFFFFFF},  "s_neg_div0");

        // Flush in the tenth busy cycle.
        @(posedge clk); #1;
        a = 32'd1000; b = 32'd7; divsigned = 1'b0; divstart = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        annul = 1'b1; divstart = 1'b0;
        @(posedge clk); #1;
        annul = 1'b0;
        @(negedge clk);
        check("annul_stall", div_stall, 1'b0);
        rdy = 0;
        repeat (40) begin
            @(negedge clk);
            if (div_ready) rdy++;
        end
        check("annul_noready", rdy, 0);
        check("annul_hold", divres, last_lit);

        // Asynchronous reset in the middle of an operation.
        @(posedge clk); #1;
        a = 32'd1000; b = 32'd3; divsigned = 1'b0; divstart = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        #2 resetn = 1'b0; divstart = 1'b0;
        #1;
        check("rst_mid_divres", divres, 64'd0);
        check("rst_mid_ready", div_ready, 1'b0);
        check("rst_mid_stall", div_stall, 1'b0);
        #3 resetn = 1'b1;
        do_div(32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, "post_rst");

        // Back-to-back with divstart held throughout.
        @(posedge clk); #1;
        a = 32'd50; b = 32'd5; divsigned = 1'b0; divstart = 1'b1;
        wait_ready(r1, t1);
        @(posedge clk); #1;
        a = 32'hFFFFFFFF; b = 32'h10;
        wait_ready(r2, t2);
        @(posedge clk); #1;
        divstart = 1'b0;
        check("b2b_first", r1, {32'd0, 32'd10});
        check("b2b_second", r2, {32'hF, 32'h0FFFFFFF});
        check("b2b_spacing", t2 - t1, 34);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
